// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and defaults for the stopwatch control unit.
// State encodings are fixed because the display/debug tooling decodes them.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  localparam int unsigned DIV_DEFAULT = 10_000_000;
  localparam int unsigned CW_DEFAULT  = 24;

  typedef struct packed {
    logic [3:0] qm;
    logic [7:0] qs;
    logic [3:0] q0;
  } disp_t;

  // The prescaler advances only in these states.
  function automatic logic is_counting(input state_e s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Raw asynchronous button -> 2-FF synchronizer -> registered one-cycle rising-edge pulse.
// A rise sampled at edge k yields pulse_o high for the cycle after edge k+2.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  assign pulse_d = sync_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing: two buttons drive IDLE/RUN/LAP/STOP, a prescaler makes the
// counter-chain enable, and the display either follows the live count or holds a lap.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT,
  parameter int unsigned CW  = CW_DEFAULT
) (
  input  logic       clk,
  input  logic       r,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic [3:0] q0,
  input  logic [7:0] qs,
  input  logic [3:0] qm,
  output logic       en,
  output logic       clr,
  output logic [3:0] disp_q0,
  output logic [7:0] disp_qs,
  output logic [3:0] disp_qm,
  output logic       running,
  output logic       lap
);

  localparam logic [CW-1:0] PRESC_TOP = CW'(DIV - 1);

  logic ss_p;
  logic lr_p;

  btn_edge u_ss (
    .clk     (clk),
    .rst     (r),
    .btn_i   (btn_ss),
    .pulse_o (ss_p)
  );

  btn_edge u_lr (
    .clk     (clk),
    .rst     (r),
    .btn_i   (btn_lr),
    .pulse_o (lr_p)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic          en_q, en_d;
  logic          clr_q, clr_d;
  logic          presc_clr;
  logic          cnt_act;
  disp_t         disp_q, disp_d;
  disp_t         live;

  // Start/stop has priority: when both pulses coincide lr_p is simply ignored.
  always_comb begin
    state_d   = state_q;
    clr_d     = 1'b0;
    presc_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_p) begin
          state_d   = S_RUN;
          presc_clr = 1'b1;
        end else if (lr_p) begin
          clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (ss_p)      state_d = S_STOP;
        else if (lr_p) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_p)      state_d = S_STOP;
        else if (lr_p) state_d = S_RUN;
      end
      S_STOP: begin
        if (ss_p) begin
          state_d = S_RUN;
        end else if (lr_p) begin
          state_d   = S_IDLE;
          clr_d     = 1'b1;
          presc_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counting requires staying in RUN/LAP across the edge, so a tick that would
  // land on the edge leaving RUN/LAP is withheld and en never shows up in STOP.
  assign cnt_act = is_counting(state_q) && is_counting(state_d);

  always_comb begin
    presc_d = presc_q;
    en_d    = 1'b0;
    if (presc_clr) begin
      presc_d = '0;
    end else if (cnt_act) begin
      if (presc_q == PRESC_TOP) begin
        presc_d = '0;
        en_d    = 1'b1;
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end
  end

  assign live = '{qm: qm, qs: qs, q0: q0};

  // Entering LAP captures the live count; only staying in LAP holds it.
  always_comb begin
    disp_d = live;
    if ((state_q == S_LAP) && (state_d == S_LAP)) begin
      disp_d = disp_q;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      disp_q  <= disp_d;
    end
  end

  assign en      = en_q;
  assign clr     = clr_q;
  assign disp_q0 = disp_q.q0;
  assign disp_qs = disp_q.qs;
  assign disp_qm = disp_q.qm;
  assign running = is_counting(state_q);
  assign lap     = (state_q == S_LAP);

endmodule
